// File: rtl/sfilt_seq.sv
// Command sequencer feeding the sfilt MAC stage: keeps the sample delay line and
// coefficient bank, and emits one cmd0/cmd1.../cmd2/cmd3 burst per accepted sample.
module sfilt_seq #(
  parameter int NTAPS = 8,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pushin,
  input  logic [31:0]   din,
  input  logic [6:0]    shamt,
  output logic          ready,
  input  logic          cload,
  input  logic [AW-1:0] caddr,
  input  logic [31:0]   cdata,
  output logic          cerr,
  output logic          pushout,
  output logic [1:0]    cmd,
  output logic [31:0]   q,
  output logic [31:0]   h
);

  // state | meaning
  // IDLE  | no burst on the outputs, ready=1, sample/coefficient writes accepted
  // MAC   | outputs carry tap k (cmd0 for k=0, cmd1 otherwise)
  // SHIFT | outputs carry cmd2 with the latched shift amount
  // OUT   | outputs carry cmd3; write pointer advances on leaving
  typedef enum logic [1:0] {IDLE, MAC, SHIFT, OUT} state_t;

  localparam int             IW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IW-1:0]  KLAST = IW'(NTAPS - 1);
  localparam logic [AW:0]    CNT   = (AW + 1)'(NTAPS);

  state_t        state, state_n;
  logic [IW-1:0] k, k_n, wptr, wptr_n;
  logic [6:0]    shamt_r;
  logic [31:0]   line [NTAPS];
  logic [31:0]   coef [NTAPS];

  logic          ready_n, pushout_n;
  logic [1:0]    cmd_n;
  logic [31:0]   q_n, h_n;

  logic          accept, caddr_ok, cwr, cerr_n;
  logic [IW-1:0] nk, off, rd_idx;
  logic [31:0]   coef0;

  assign accept   = pushin & ready;
  assign caddr_ok = {1'b0, caddr} < CNT;
  assign cwr      = cload & ready & caddr_ok;
  assign cerr_n   = cload & ~cwr;
  // cmd0 goes out on the accept edge, so a same-cycle write to coef[0] is forwarded
  assign coef0    = (cwr && caddr[IW-1:0] == '0) ? cdata : coef[0];

  // Outputs show tap k; the next tap read is k+1, never the slot being written.
  assign nk     = k + 1'b1;
  assign off    = KLAST - nk + 1'b1;
  assign rd_idx = (wptr >= nk) ? (wptr - nk) : (wptr + off);

  always_comb begin
    state_n   = state;
    k_n       = k;
    wptr_n    = wptr;
    ready_n   = 1'b0;
    pushout_n = 1'b0;
    cmd_n     = 2'd0;
    q_n       = 32'd0;
    h_n       = 32'd0;
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (accept) begin
          state_n   = MAC;
          k_n       = '0;
          ready_n   = 1'b0;
          pushout_n = 1'b1;
          cmd_n     = 2'd0;
          q_n       = din;
          h_n       = coef0;
        end
      end
      MAC: begin
        pushout_n = 1'b1;
        if (k == KLAST) begin
          state_n = SHIFT;
          cmd_n   = 2'd2;
          h_n     = {25'd0, shamt_r};
        end else begin
          k_n   = nk;
          cmd_n = 2'd1;
          q_n   = line[rd_idx];
          h_n   = coef[nk];
        end
      end
      SHIFT: begin
        state_n   = OUT;
        pushout_n = 1'b1;
        cmd_n     = 2'd3;
      end
      OUT: begin
        state_n = IDLE;
        ready_n = 1'b1;
        wptr_n  = (wptr == KLAST) ? '0 : wptr + 1'b1;
      end
      default: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      wptr    <= '0;
      shamt_r <= '0;
      ready   <= 1'b1;
      pushout <= 1'b0;
      cmd     <= 2'd0;
      q       <= 32'd0;
      h       <= 32'd0;
      cerr    <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        line[i] <= 32'd0;
        coef[i] <= 32'd0;
      end
    end else begin
      state   <= state_n;
      k       <= k_n;
      wptr    <= wptr_n;
      ready   <= ready_n;
      pushout <= pushout_n;
      cmd     <= cmd_n;
      q       <= q_n;
      h       <= h_n;
      cerr    <= cerr_n;
      if (accept) begin
        line[wptr] <= din;
        shamt_r    <= shamt;
      end
      if (cwr)
        coef[caddr[IW-1:0]] <= cdata;
    end
  end

endmodule

// File: tb/tb_sfilt_seq.sv
// Directed bench for sfilt_seq (NTAPS=4): checks burst contents, timing, coefficient
// write rules and reset, folding each burst through a small sfilt model for z.
module tb_sfilt_seq;
  localparam int N  = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst, pushin, cload;
  logic [31:0]   din, cdata;
  logic [6:0]    shamt;
  logic [AW-1:0] caddr;
  logic          ready, cerr, pushout;
  logic [1:0]    cmd;
  logic [31:0]   q, h;

  int checks = 0;
  int errors = 0;

  logic        bp [N+2];
  logic [1:0]  bc [N+2];
  logic [31:0] bq [N+2];
  logic [31:0] bh [N+2];
  longint      bz;

  sfilt_seq #(.NTAPS(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .pushin(pushin), .din(din), .shamt(shamt), .ready(ready),
    .cload(cload), .caddr(caddr), .cdata(cdata), .cerr(cerr),
    .pushout(pushout), .cmd(cmd), .q(q), .h(h)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, want 1", ready, n);
    end
  endtask

  task automatic load_coef(input int a, input int d);
    wait_ready();
    cload = 1'b1;
    caddr = AW'(a);
    cdata = 32'(d);
    step();
    cload = 1'b0;
  endtask

  task automatic push(input int d, input int s);
    wait_ready();
    pushin = 1'b1;
    din    = 32'(d);
    shamt  = 7'(s);
    step();
    pushin = 1'b0;
  endtask

  // Records N+2 output cycles and runs them through an sfilt reference.
  task automatic capture_burst();
    longint acc = 0;
    int     s;
    bz = 0;
    for (int i = 0; i < N + 2; i++) begin
      bp[i] = pushout;
      bc[i] = cmd;
      bq[i] = q;
      bh[i] = h;
      if (pushout) begin
        case (cmd)
          2'd0: acc = longint'($signed(q)) * longint'($signed(h));
          2'd1: acc = acc + longint'($signed(q)) * longint'($signed(h));
          2'd2: begin
            s = int'(h[6:0]);
            if (s > 0) acc = (acc + (longint'(1) <<< (s - 1))) >>> s;
          end
          default: bz = acc;
        endcase
      end
      step();
    end
  endtask

  function automatic logic [1:0] exp_cmd(input int i);
    return (i == 0) ? 2'd0 : (i < N) ? 2'd1 : (i == N) ? 2'd2 : 2'd3;
  endfunction

  task automatic test_reset();
    checks++;
    if ({ready, pushout, cmd, q, h, cerr} !== {1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: ready=%b pushout=%b cmd=%0d q=%0d h=%0d cerr=%b, want 1 0 0 0 0 0",
               ready, pushout, cmd, q, h, cerr);
    end
  endtask

  task automatic test_basic();
    int eq3 [N] = '{30, 20, 10, 0};
    int eq1 [N] = '{10, 0, 0, 0};
    logic [31:0] wq, wh;
    for (int a = 0; a < N; a++) load_coef(a, a + 1);
    push(10, 0);
    capture_burst();
    for (int i = 0; i < N + 2; i++) begin
      wq = (i < N) ? 32'(eq1[i]) : 32'd0;
      wh = (i < N) ? 32'(i + 1) : 32'd0;
      checks++;
      if ({bp[i], bc[i], bq[i], bh[i]} !== {1'b1, exp_cmd(i), wq, wh}) begin
        errors++;
        $display("FAIL basic_s1 cyc%0d: p=%b cmd=%0d q=%0d h=%0d, want p=1 cmd=%0d q=%0d h=%0d",
                 i, bp[i], bc[i], bq[i], bh[i], exp_cmd(i), wq, wh);
      end
    end
    checks++;
    if (bz !== 10) begin errors++; $display("FAIL basic_z1: z=%0d want 10", bz); end
    checks++;
    if ({ready, pushout} !== 2'b10) begin
      errors++;
      $display("FAIL basic_after: ready=%b pushout=%b, want 1 0", ready, pushout);
    end
    push(20, 0);
    capture_burst();
    checks++;
    if (bz !== 40) begin errors++; $display("FAIL basic_z2: z=%0d want 40", bz); end
    push(30, 0);
    capture_burst();
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({bq[i], bh[i]} !== {32'(eq3[i]), 32'(i + 1)}) begin
        errors++;
        $display("FAIL basic_s3 tap%0d: q=%0d h=%0d, want q=%0d h=%0d",
                 i, bq[i], bh[i], eq3[i], i + 1);
      end
    end
    checks++;
    if (bz !== 100) begin errors++; $display("FAIL basic_z3: z=%0d want 100", bz); end
  endtask

  task automatic test_wrap();
    int eq [N] = '{6, 5, 4, 3};
    do_reset();
    for (int a = 0; a < N; a++) load_coef(a, 1);
    for (int sidx = 1; sidx <= N + 2; sidx++) begin
      push(sidx, 0);
      capture_burst();
      if (sidx == 5) begin
        checks++;
        if (bz !== 14) begin errors++; $display("FAIL wrap_z5: z=%0d want 14", bz); end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bq[i] !== 32'(eq[i])) begin
        errors++;
        $display("FAIL wrap_q tap%0d: q=%0d want %0d", i, bq[i], eq[i]);
      end
    end
    checks++;
    if (bz !== 18) begin errors++; $display("FAIL wrap_z6: z=%0d want 18", bz); end
  endtask

  task automatic test_shift();
    do_reset();
    load_coef(0, 8);
    push(5, 3);
    capture_burst();
    checks++;
    if ({bc[N], bh[N]} !== {2'd2, 32'd3}) begin
      errors++;
      $display("FAIL shift_h: cmd=%0d h=%0d, want cmd=2 h=3", bc[N], bh[N]);
    end
    checks++;
    if (bz !== 5) begin errors++; $display("FAIL shift_z: z=%0d want 5", bz); end
  endtask

  task automatic test_cerr();
    int wh [N] = '{5, 2, 0, 0};
    int wq [N] = '{3, 7, 7, 5};
    push(7, 0);
    cload = 1'b1; caddr = '0; cdata = 32'd99;
    step();
    cload = 1'b0;
    checks++;
    if (cerr !== 1'b1) begin errors++; $display("FAIL cerr_busy: cerr=%b want 1", cerr); end
    step();
    checks++;
    if (cerr !== 1'b0) begin errors++; $display("FAIL cerr_pulse: cerr=%b want 0", cerr); end
    push(7, 0);
    capture_burst();
    checks++;
    if (bh[0] !== 32'd8) begin errors++; $display("FAIL cerr_coef0: h=%0d want 8", bh[0]); end
    wait_ready();
    cload = 1'b1; caddr = AW'(N); cdata = 32'd77;
    step();
    cload = 1'b0;
    checks++;
    if (cerr !== 1'b1) begin errors++; $display("FAIL cerr_range: cerr=%b want 1", cerr); end
    load_coef(1, 2);
    checks++;
    if (cerr !== 1'b0) begin errors++; $display("FAIL cerr_valid: cerr=%b want 0", cerr); end
    wait_ready();
    cload = 1'b1; caddr = '0; cdata = 32'd5;
    pushin = 1'b1; din = 32'd3; shamt = 7'd0;
    step();
    cload = 1'b0; pushin = 1'b0;
    capture_burst();
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({bq[i], bh[i]} !== {32'(wq[i]), 32'(wh[i])}) begin
        errors++;
        $display("FAIL cload_push tap%0d: q=%0d h=%0d, want q=%0d h=%0d",
                 i, bq[i], bh[i], wq[i], wh[i]);
      end
    end
    checks++;
    if (bz !== 29) begin errors++; $display("FAIL cload_push_z: z=%0d want 29", bz); end
  endtask

  task automatic test_back_to_back();
    logic wp;
    int   starts = 0;
    wait_ready();
    pushin = 1'b1; din = 32'd1; shamt = 7'd0;
    for (int j = 0; j < 3 * (N + 3); j++) begin
      step();
      if (j == 3 * (N + 3) - 1) pushin = 1'b0;
      wp = (j % (N + 3)) != (N + 2);
      if (pushout && cmd == 2'd0) starts++;
      checks++;
      if ({pushout, ready} !== {wp, ~wp}) begin
        errors++;
        $display("FAIL b2b cyc%0d: pushout=%b ready=%b, want %b %b", j, pushout, ready, wp, ~wp);
      end
    end
    checks++;
    if (starts !== 3) begin errors++; $display("FAIL b2b_count: bursts=%0d want 3", starts); end
    wait_ready();
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < N; a++) load_coef(a, a + 1);
    push(9, 0); capture_burst();
    push(8, 0); capture_burst();
    push(7, 0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({pushout, ready} !== 2'b01) begin
      errors++;
      $display("FAIL rst_mid: pushout=%b ready=%b, want 0 1", pushout, ready);
    end
    push(11, 0);
    capture_burst();
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({bq[i], bh[i]} !== {(i == 0) ? 32'd11 : 32'd0, 32'd0}) begin
        errors++;
        $display("FAIL rst_clear tap%0d: q=%0d h=%0d, want q=%0d h=0",
                 i, bq[i], bh[i], (i == 0) ? 11 : 0);
      end
    end
    checks++;
    if (bz !== 0) begin errors++; $display("FAIL rst_z: z=%0d want 0", bz); end
  endtask

  initial begin
    rst = 1'b1; pushin = 1'b0; cload = 1'b0;
    din = '0; cdata = '0; shamt = '0; caddr = '0;
    step();
    step();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_shift();
    test_cerr();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
